mmio_arbiter: RTL
=================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from bus issue to valid bus_rdata; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  requester 0 (CPU data port) access request; held until m0_gnt.
REQ-005 m0_we / m0_size / m0_unsigned  input  1/2/1  write flag; size 00=byte, 01=half, 10=word; 11 reserved; zero-extend loads.
REQ-006 m0_addr / m0_wdata  input  32/32  byte address; store data.
REQ-007 m0_gnt / m0_rvalid  output  1/1  single-cycle request-accepted pulse; single-cycle completion pulse.
REQ-008 m0_rdata  output  32  load data, valid only while m0_rvalid=1.
REQ-009 m1_req, m1_we, m1_size, m1_unsigned, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: requester 1 (debug/boot loader), same widths and meanings as m0.
REQ-010 bus_en  output  1  high exactly one cycle per issued access.
REQ-011 bus_we / bus_size / bus_unsigned / bus_addr / bus_wdata  output  1/2/1/32/32  registered copy of the granted request.
REQ-012 bus_rdata  input  32  data returned by the shared mmio port.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at any time.
REQ-015 IDLE: any req high -> latch winner's fields into bus_* registers, pulse winner's gnt that same cycle, go to ISSUE; no req -> stay.
REQ-016 ISSUE: bus_en=1 for this one cycle; go to WAIT with latency counter loaded to RD_LAT-1.
REQ-017 WAIT: counter decrements each cycle; at 0 sample bus_rdata into the owner's rdata register, go to RESP; RD_LAT=1 spends exactly one WAIT cycle.
REQ-018 RESP: owner's rvalid=1 for one cycle, then IDLE; writes also complete through WAIT/RESP (rvalid acknowledges the store, rdata holds previous value).
REQ-019 Latency: request seen in IDLE at cycle N -> gnt at N, bus_en at N+1, rvalid at N+2+RD_LAT.
REQ-020 Requests arriving outside IDLE are ignored until next IDLE; no gnt is lost or duplicated.
REQ-021 Non-owner's rvalid and gnt stay 0 throughout a transaction; non-owner rdata holds its last value.
REQ-022 size=11 is accepted as a word access; address alignment is not checked (downstream responsibility).
REQ-023 bus_* outputs hold their last granted value while bus_en=0.
REQ-024 Minimum spacing between back-to-back grants is RD_LAT+3 cycles.

Reset
REQ-025 rst_n low, at any time including mid-transaction, forces IDLE within the same cycle with no clock required.
REQ-026 Reset values: all gnt, rvalid, bus_en, bus_we, busy = 0; bus_size=00; bus_unsigned=0; bus_addr, bus_wdata, m0_rdata, m1_rdata = 0; counter=0; round-robin pointer favours m0.
REQ-027 A transaction aborted by reset produces no rvalid after reset release.

Configuration
REQ-028 Macro MMIO_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant goes to the requester not served by the most recent grant; pointer updates only on a grant.
REQ-029 MMIO_ARB_ROUND_ROBIN_EN undefined: fixed priority, m0 always wins simultaneous requests; m1 can be starved.
REQ-030 A single request is granted immediately in both configurations.

Verification
REQ-031 RD_LAT=1, m0 load word addr 0x100, bus_rdata=0xDEADBEEF -> gnt cycle 0, bus_en cycle 1, m0_rvalid cycle 3 with m0_rdata=0xDEADBEEF.
REQ-032 m1 store byte addr 0x32000 data 0x41 -> bus_en one cycle with bus_we=1, bus_size=00, bus_addr=0x32000, bus_wdata=0x41; m1_rvalid 3 cycles after gnt; m0 outputs stay 0.
REQ-033 m0_req and m1_req held high continuously for 4 transactions -> with MMIO_ARB_ROUND_ROBIN_EN grants m0,m1,m0,m1; without it grants m0,m0,m0,m0.
REQ-034 RD_LAT=3, m0 load -> rvalid exactly 5 cycles after gnt; bus_rdata sampled on the cycle before rvalid only.
REQ-035 rst_n asserted during WAIT -> busy and all pulses 0 immediately; after release no rvalid appears; next request granted normally.
REQ-036 m1 requests during an m0 transaction -> m1_gnt in the first IDLE cycle after m0_rvalid, never earlier.

Source files
------------

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-requester arbiter feeding one MMIO port, one transaction outstanding at a time.
// Define MMIO_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed m0 priority.
module mmio_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        bus_en,
  output logic        bus_we,
  output logic [1:0]  bus_size,
  output logic        bus_unsigned,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state, next;
  logic [2:0] cnt;
  logic       owner, win, any, take;
  logic [1:0] req_size;
  assign any  = m0_req | m1_req;
  assign take = (state == IDLE) && any;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
  logic last;
  assign win = (m0_req && m1_req) ? ~last : m1_req;
  // last=1 at reset so the first contested grant goes to m0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (take) last <= win;
`else
  assign win = ~m0_req;
`endif
  assign req_size = win ? m1_size : m0_size;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = any ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = (cnt == 3'd0) ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end
  // gnt is combinational from req, so it is gated by rst_n to stay low during reset
  always_comb begin
    m0_gnt    = rst_n && (state == IDLE) && m0_req && !win;
    m1_gnt    = rst_n && (state == IDLE) && m1_req && win;
    bus_en    = state == ISSUE;
    busy      = state != IDLE;
    m0_rvalid = (state == RESP) && !owner;
    m1_rvalid = (state == RESP) && owner;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner        <= 1'b0;
      cnt          <= 3'd0;
      bus_we       <= 1'b0;
      bus_size     <= 2'b00;
      bus_unsigned <= 1'b0;
      bus_addr     <= 32'd0;
      bus_wdata    <= 32'd0;
      m0_rdata     <= 32'd0;
      m1_rdata     <= 32'd0;
    end else begin
      if (take) begin
        owner        <= win;
        bus_we       <= win ? m1_we : m0_we;
        bus_size     <= (req_size == 2'b11) ? 2'b10 : req_size;
        bus_unsigned <= win ? m1_unsigned : m0_unsigned;
        bus_addr     <= win ? m1_addr : m0_addr;
        bus_wdata    <= win ? m1_wdata : m0_wdata;
      end
      if (state == ISSUE) cnt <= 3'(RD_LAT - 1);
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd0 && !bus_we && !owner) m0_rdata <= bus_rdata;
      if (state == WAIT && cnt == 3'd0 && !bus_we && owner) m1_rdata <= bus_rdata;
    end
endmodule
